// File: rtl/cim_pkg.sv
// Shared types and constants for the compute-in-memory row sequencer.
package cim_pkg;

   localparam int ROWS = 4;
   localparam int COLS = 4;

   typedef enum logic [1:0] {
      OP_WRITE    = 2'd0,
      OP_READ     = 2'd1,
      OP_SEARCH   = 2'd2,
      OP_MAC_SCAN = 2'd3
   } op_e;

   // Explicit encodings keep the state register readable in legacy dumps.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      PRE   = 3'd1,
      DRV   = 3'd2,
      SENSE = 3'd3,
      RESP  = 3'd4
   } state_e;

endpackage

// File: rtl/cim_phase_timer.sv
// Loadable down-counter; done is high in the last cycle of a phase.
module cim_phase_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/cim_row_ctrl.sv
// Command sequencer for the 4-row CAM/MAC wordline decoder: precharge,
// wordline drive and sense phases, one response per accepted command.
module cim_row_ctrl
   import cim_pkg::*;
#(
   parameter int PRE_CYC = 2,
   parameter int DRV_CYC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [1:0] cmd_addr,
   input  logic [3:0] cmd_data,
   output logic       mac_en,
   output logic       read_bar,
   output logic       w_en,
   output logic [1:0] addr,
   output logic [3:0] key,
   output logic [3:0] wdata,
   output logic       pre_en,
   output logic       drive_en,
   output logic       sa_en,
   input  logic [3:0] sense_in,
   output logic       rsp_valid,
   output logic [4:0] rsp_data
);

   localparam int MAXC = (PRE_CYC > DRV_CYC) ? PRE_CYC : DRV_CYC;
   localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [CW-1:0] PRE_LD = CW'(PRE_CYC - 1);
   localparam logic [CW-1:0] DRV_LD = CW'(DRV_CYC - 1);

   state_e      state, state_nx;
   op_e         op_q, op_nx;
   logic [1:0]  cap_addr, cap_addr_nx;
   logic [3:0]  cap_data, cap_data_nx;
   logic [1:0]  row_q, row_nx;
   logic [4:0]  acc_q, acc_nx;
   logic [4:0]  rsp_nx;
   logic [4:0]  pop;
   logic        accept;
   logic        tmr_load;
   logic [CW-1:0] tmr_val;
   logic        tmr_done;

   logic        busy_nx;
   logic        drv_mac_en, drv_w_en;
   logic [1:0]  drv_addr;
   logic [3:0]  drv_key, drv_wdata;

   assign accept = cmd_valid & cmd_ready;
   assign pop = 5'(sense_in[0]) + 5'(sense_in[1]) + 5'(sense_in[2]) + 5'(sense_in[3]);

   cim_phase_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   always_comb begin
      state_nx    = state;
      op_nx       = op_q;
      cap_addr_nx = cap_addr;
      cap_data_nx = cap_data;
      row_nx      = row_q;
      acc_nx      = acc_q;
      rsp_nx      = rsp_data;
      tmr_load    = 1'b0;
      tmr_val     = PRE_LD;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx    = PRE;
               op_nx       = op_e'(cmd_op);
               cap_addr_nx = cmd_addr;
               cap_data_nx = cmd_data;
               row_nx      = 2'd0;
               acc_nx      = 5'd0;
               tmr_load    = 1'b1;
               tmr_val     = PRE_LD;
            end
         end
         PRE: begin
            if (tmr_done) begin
               state_nx = DRV;
               tmr_load = 1'b1;
               tmr_val  = DRV_LD;
            end
         end
         DRV: begin
            if (tmr_done) begin
               if (op_q == OP_WRITE) begin
                  state_nx = RESP;
                  rsp_nx   = 5'd0;
               end else begin
                  state_nx = SENSE;
               end
            end
         end
         SENSE: begin
            if (op_q == OP_MAC_SCAN) begin
               acc_nx = acc_q + pop;
               if (row_q == 2'(ROWS - 1)) begin
                  state_nx = RESP;
                  rsp_nx   = acc_q + pop;
               end else begin
                  // Next row re-runs the full precharge/drive/sense cycle.
                  row_nx   = row_q + 2'd1;
                  state_nx = PRE;
                  tmr_load = 1'b1;
                  tmr_val  = PRE_LD;
               end
            end else begin
               state_nx = RESP;
               rsp_nx   = {1'b0, sense_in};
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Mode outputs are decoded from next-state values so they can be registered
   // and still line up with the phase they belong to.
   always_comb begin
      busy_nx    = (state_nx == PRE) || (state_nx == DRV) || (state_nx == SENSE);
      drv_mac_en = 1'b1;
      drv_w_en   = 1'b0;
      drv_addr   = 2'd0;
      drv_key    = 4'd0;
      drv_wdata  = 4'd0;
      if (busy_nx) begin
         case (op_nx)
            OP_WRITE: begin
               drv_w_en  = 1'b1;
               drv_addr  = cap_addr_nx;
               drv_wdata = cap_data_nx;
            end
            OP_READ:   drv_addr = cap_addr_nx;
            OP_SEARCH: begin
               drv_mac_en = 1'b0;
               drv_key    = cap_data_nx;
            end
            default:   drv_addr = row_nx;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_q      <= OP_WRITE;
         cap_addr  <= 2'd0;
         cap_data  <= 4'd0;
         row_q     <= 2'd0;
         acc_q     <= 5'd0;
         cmd_ready <= 1'b1;
         mac_en    <= 1'b1;
         read_bar  <= 1'b0;
         w_en      <= 1'b0;
         addr      <= 2'd0;
         key       <= 4'd0;
         wdata     <= 4'd0;
         pre_en    <= 1'b0;
         drive_en  <= 1'b0;
         sa_en     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_data  <= 5'd0;
      end else begin
         state     <= state_nx;
         op_q      <= op_nx;
         cap_addr  <= cap_addr_nx;
         cap_data  <= cap_data_nx;
         row_q     <= row_nx;
         acc_q     <= acc_nx;
         cmd_ready <= (state_nx == IDLE);
         mac_en    <= drv_mac_en;
         read_bar  <= 1'b0;
         w_en      <= drv_w_en;
         addr      <= drv_addr;
         key       <= drv_key;
         wdata     <= drv_wdata;
         pre_en    <= (state_nx == PRE);
         drive_en  <= (state_nx == DRV) || (state_nx == SENSE);
         sa_en     <= (state_nx == SENSE);
         rsp_valid <= (state_nx == RESP);
         rsp_data  <= rsp_nx;
      end
   end

endmodule

// File: tb/tb_cim_row_ctrl.sv
// Directed bench for cim_row_ctrl: vector table plus reset/busy corner sequences.
module tb_cim_row_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [1:0] cmd_addr;
   logic [3:0] cmd_data;
   logic       mac_en, read_bar, w_en;
   logic [1:0] addr;
   logic [3:0] key, wdata;
   logic       pre_en, drive_en, sa_en;
   logic [3:0] sense_in;
   logic       rsp_valid;
   logic [4:0] rsp_data;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [1:0]       op;
      logic [1:0]       a;
      logic [3:0]       d;
      logic [3:0][3:0]  sense;   // sense[k] is returned in the k-th SENSE cycle
      int               lat;
      logic [4:0]       rsp;
   } vec_t;

   vec_t vt[9];

   cim_row_ctrl #(.PRE_CYC(2), .DRV_CYC(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .mac_en    (mac_en),
      .read_bar  (read_bar),
      .w_en      (w_en),
      .addr      (addr),
      .key       (key),
      .wdata     (wdata),
      .pre_en    (pre_en),
      .drive_en  (drive_en),
      .sa_en     (sa_en),
      .sense_in  (sense_in),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_reset(input string nm);
      chk({nm, " cmd_ready"}, 32'(cmd_ready), 32'd1);
      chk({nm, " mac_en"},    32'(mac_en),    32'd1);
      chk({nm, " read_bar"},  32'(read_bar),  32'd0);
      chk({nm, " w_en"},      32'(w_en),      32'd0);
      chk({nm, " addr"},      32'(addr),      32'd0);
      chk({nm, " key"},       32'(key),       32'd0);
      chk({nm, " wdata"},     32'(wdata),     32'd0);
      chk({nm, " pre_en"},    32'(pre_en),    32'd0);
      chk({nm, " drive_en"},  32'(drive_en),  32'd0);
      chk({nm, " sa_en"},     32'(sa_en),     32'd0);
      chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({nm, " rsp_data"},  32'(rsp_data),  32'd0);
   endtask

   task automatic send(input logic [1:0] op, input logic [1:0] a, input logic [3:0] d, input string nm);
      chk({nm, " ready_at_issue"}, 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_addr  = 2'($urandom);
      cmd_data  = 4'($urandom);
   endtask

   // Entered in cycle 1 after acceptance; returns in the rsp_valid cycle.
   task automatic follow(input vec_t v, input string nm);
      int  sa_cnt = 0;
      int  lat    = 0;
      bit  got    = 1'b0;
      int  exp_sa = (v.op == 2'd0) ? 0 : (v.op == 2'd3) ? 4 : 1;
      for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
         chk({nm, " busy_ready"}, 32'(cmd_ready), 32'd0);
         chk({nm, " pre_drv_overlap"}, 32'(pre_en & drive_en), 32'd0);
         if (drive_en) begin
            case (v.op)
               2'd0: begin
                  chk({nm, " mac_en"},   32'(mac_en),   32'd1);
                  chk({nm, " read_bar"}, 32'(read_bar), 32'd0);
                  chk({nm, " w_en"},     32'(w_en),     32'd1);
                  chk({nm, " addr"},     32'(addr),     32'(v.a));
                  chk({nm, " wdata"},    32'(wdata),    32'(v.d));
               end
               2'd1: begin
                  chk({nm, " mac_en"},   32'(mac_en),   32'd1);
                  chk({nm, " read_bar"}, 32'(read_bar), 32'd0);
                  chk({nm, " w_en"},     32'(w_en),     32'd0);
                  chk({nm, " addr"},     32'(addr),     32'(v.a));
               end
               2'd2: begin
                  chk({nm, " mac_en"},   32'(mac_en),   32'd0);
                  chk({nm, " w_en"},     32'(w_en),     32'd0);
                  chk({nm, " key"},      32'(key),      32'(v.d));
               end
               default: begin
                  chk({nm, " mac_en"},   32'(mac_en),   32'd1);
                  chk({nm, " read_bar"}, 32'(read_bar), 32'd0);
                  chk({nm, " row_addr"}, 32'(addr),     32'(sa_cnt));
               end
            endcase
         end
         if (rsp_valid) begin
            got = 1'b1;
            lat = cyc;
         end else begin
            if (sa_en && sa_cnt < 4) begin
               sense_in = v.sense[sa_cnt];
               sa_cnt++;
            end else begin
               if (sa_en) sa_cnt++;
               sense_in = 4'($urandom);
            end
            tick();
         end
      end
      chk({nm, " rsp_seen"},  32'(got),      32'd1);
      chk({nm, " latency"},   32'(lat),      32'(v.lat));
      chk({nm, " rsp_data"},  32'(rsp_data), 32'(v.rsp));
      chk({nm, " sense_cnt"}, 32'(sa_cnt),   32'(exp_sa));
   endtask

   initial begin
      vec_t wv, rv, mv;
      bit   stray;
      int   guard;

      //               op    a     d      sense(row3..row0)  lat  rsp
      vt[0] = '{2'd0, 2'd2, 4'hA, 16'h0000,  5, 5'd0};
      vt[1] = '{2'd1, 2'd1, 4'h0, 16'h0006,  6, 5'h06};
      vt[2] = '{2'd2, 2'd0, 4'h5, 16'h0004,  6, 5'h04};
      vt[3] = '{2'd3, 2'd0, 4'h0, 16'h031F, 21, 5'd7};
      vt[4] = '{2'd3, 2'd0, 4'h0, 16'hFFFF, 21, 5'd16};
      vt[5] = '{2'd1, 2'd3, 4'h0, 16'h000F,  6, 5'h0F};
      vt[6] = '{2'd2, 2'd0, 4'hF, 16'h0000,  6, 5'h00};
      vt[7] = '{2'd0, 2'd0, 4'h5, 16'h0000,  5, 5'd0};
      vt[8] = '{2'd3, 2'd0, 4'h0, 16'h0000, 21, 5'd0};

      rst_n     = 1'b0;
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_addr  = 2'd2;
      cmd_data  = 4'h3;
      sense_in  = 4'h0;
      tick();
      tick();
      check_reset("reset_hold_valid");
      cmd_valid = 1'b0;
      rst_n     = 1'b1;
      tick();
      chk("idle_ready", 32'(cmd_ready), 32'd1);
      chk("idle_no_rsp", 32'(rsp_valid), 32'd0);

      for (int i = 0; i < 9; i++) begin
         string nm = $sformatf("vec%0d", i);
         send(vt[i].op, vt[i].a, vt[i].d, nm);
         chk({nm, " pre_first"}, 32'(pre_en), 32'd1);
         follow(vt[i], nm);
         tick();
         chk({nm, " rsp_pulse"},  32'(rsp_valid), 32'd0);
         chk({nm, " ready_back"}, 32'(cmd_ready), 32'd1);
         chk({nm, " rsp_hold"},   32'(rsp_data),  32'(vt[i].rsp));
      end

      // Command held valid while busy: ignored until the cycle after rsp_valid.
      rv = '{2'd1, 2'd1, 4'h0, 16'h0009, 6, 5'h09};
      wv = '{2'd0, 2'd3, 4'h9, 16'h0000, 5, 5'd0};
      cmd_valid = 1'b1;
      cmd_op    = 2'd1;
      cmd_addr  = 2'd1;
      cmd_data  = 4'h0;
      tick();
      cmd_op    = 2'd0;
      cmd_addr  = 2'd3;
      cmd_data  = 4'h9;
      follow(rv, "busy_read");
      tick();
      chk("busy_ready_after_rsp", 32'(cmd_ready), 32'd1);
      chk("busy_not_yet_pre",     32'(pre_en),    32'd0);
      tick();
      cmd_valid = 1'b0;
      chk("busy_late_accept_pre", 32'(pre_en), 32'd1);
      follow(wv, "busy_write");
      tick();

      // Reset in the middle of MAC_SCAN row 2.
      mv = '{2'd3, 2'd0, 4'h0, 16'h0000, 21, 5'd0};
      send(mv.op, mv.a, mv.d, "abort_mac");
      guard = 0;
      while (!(drive_en && addr == 2'd2) && guard < 40) begin
         sense_in = 4'hF;
         tick();
         guard++;
      end
      chk("abort_reached_row2", 32'(guard < 40), 32'd1);
      rst_n = 1'b0;
      tick();
      check_reset("abort_reset");
      rst_n = 1'b1;
      stray = 1'b0;
      for (int c = 0; c < 25; c++) begin
         if (rsp_valid) stray = 1'b1;
         tick();
      end
      chk("abort_no_rsp", 32'(stray), 32'd0);
      rv = '{2'd1, 2'd2, 4'h0, 16'h0003, 6, 5'h03};
      send(rv.op, rv.a, rv.d, "post_abort_read");
      follow(rv, "post_abort_read");
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
